// File: rtl/lk_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lk_pkg
// Brief   : Shared types, defaults and saturating add for the LK window path.
// Revision: 1.0  initial release
// ============================================================================
package lk_pkg;

    localparam int c_sumd_int_default = 6;
    // Wide enough that any SUMD_INT-bit operand pair adds without wrapping.
    localparam int c_sat_w            = 16;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FILL       = 3'd1,
        ST_LOAD       = 3'd2,
        ST_READ       = 3'd3,
        ST_WAIT_DELTA = 3'd4,
        ST_UPDATE     = 3'd5,
        ST_DONE       = 3'd6
    } lk_state_t;

    function automatic logic signed [c_sat_w-1:0] sat_add(
        input logic signed [c_sat_w-1:0] a,
        input logic signed [c_sat_w-1:0] b,
        input logic signed [c_sat_w-1:0] lim
    );
        logic signed [c_sat_w-1:0] s;
        s = a + b;
        if (s > lim)
            return lim;
        else if (s < -lim)
            return -lim;
        else
            return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lk_window_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : lk_window_sequencer_if
// Brief   : Row-buffer and solver signals between the sequencer and its peers.
// Revision: 1.0  initial release
// ============================================================================
interface lk_window_sequencer_if #(
    parameter int SUMD_INT = 6
) ();
    logic                       fifo_clr;
    logic                       fifo_w_en;
    logic                       fifo_load_addr;
    logic                       fifo_r_en;
    logic                       fifo_full;
    logic                       fifo_window_done;
    logic signed [SUMD_INT-1:0] sum_dr;
    logic signed [SUMD_INT-1:0] sum_dc;
    logic                       delta_valid;
    logic signed [SUMD_INT-1:0] delta_dr;
    logic signed [SUMD_INT-1:0] delta_dc;

    modport master (
        output fifo_clr, fifo_w_en, fifo_load_addr, fifo_r_en, sum_dr, sum_dc,
        input  fifo_full, fifo_window_done, delta_valid, delta_dr, delta_dc
    );

    modport slave (
        input  fifo_clr, fifo_w_en, fifo_load_addr, fifo_r_en, sum_dr, sum_dc,
        output fifo_full, fifo_window_done, delta_valid, delta_dr, delta_dc
    );
endinterface
`default_nettype wire

// File: rtl/lk_win_watchdog.sv
`default_nettype none
// ============================================================================
// Module  : lk_win_watchdog
// Brief   : Counts read-enable cycles of one window; flags a missing completion.
// Revision: 1.0  initial release
// ============================================================================
module lk_win_watchdog #(
    parameter int WIN_CYCLES = 49
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_active,
    input  wire logic i_window_done,
    input  wire logic i_clr,
    output logic      o_timeout,
    output logic      o_win_err
);
    // Two cycles of slack beyond the nominal window before giving up.
    localparam int c_limit = WIN_CYCLES + 2;
    localparam int c_cnt_w = $clog2(c_limit + 1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (i_active)
            r_cnt <= r_cnt + 1'b1;
        else
            r_cnt <= '0;
    end

    assign o_timeout = i_active & ~i_window_done & (r_cnt == c_cnt_w'(c_limit - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            o_win_err <= 1'b0;
        else if (i_clr)
            o_win_err <= 1'b0;
        else if (o_timeout)
            o_win_err <= 1'b1;
    end
endmodule
`default_nettype wire

// File: rtl/lk_window_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : lk_window_sequencer
// Brief   : Fill / load / read / update iteration controller for the LK window
//           buffer. Define LK_EARLY_EXIT_EN to stop on a zero update.
// Revision: 1.0  initial release
// ============================================================================
module lk_window_sequencer
    import lk_pkg::*;
#(
    parameter int SUMD_INT   = c_sumd_int_default,
    parameter int ROWS       = 33,
    parameter int COLS       = 33,
    parameter int MAX_ITER   = 5,
    parameter int MAX_DISP   = 12,
    parameter int WIN_CYCLES = 49
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             start,
    input  wire logic             pix_valid,
    lk_window_sequencer_if.master bus,
    output logic [3:0]            iter_count,
    output logic                  busy,
    output logic                  done,
    output logic                  win_err
);
    localparam int c_pix_total = ROWS * COLS;
    localparam int c_pix_w     = $clog2(c_pix_total + 1);

    lk_state_t                  r_state, w_next;
    logic [c_pix_w-1:0]         r_pix_cnt;
    logic signed [SUMD_INT-1:0] r_sum_dr, r_sum_dc, r_delta_dr, r_delta_dc;
    logic [3:0]                 r_iter;
    logic w_accept, w_last_pix, w_timeout, w_exit;
    logic w_clr, w_w_en, w_load, w_r_en;

    assign w_accept   = (r_state == ST_FILL) & pix_valid & ~bus.fifo_full;
    assign w_last_pix = w_accept & (r_pix_cnt == c_pix_w'(c_pix_total - 1));

`ifdef LK_EARLY_EXIT_EN
    assign w_exit = ((r_iter + 4'd1) == 4'(MAX_ITER)) |
                    ((r_delta_dr == '0) && (r_delta_dc == '0));
`else
    assign w_exit = ((r_iter + 4'd1) == 4'(MAX_ITER));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_clr  = 1'b0;
        w_w_en = 1'b0;
        w_load = 1'b0;
        w_r_en = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_clr  = 1'b1;
                    w_next = ST_FILL;
                end
            end
            ST_FILL: begin
                w_w_en = w_accept;
                if (w_last_pix)
                    w_next = ST_LOAD;
            end
            ST_LOAD: begin
                w_load = 1'b1;
                w_next = ST_READ;
            end
            ST_READ: begin
                w_r_en = 1'b1;
                if (bus.fifo_window_done || w_timeout)
                    w_next = ST_WAIT_DELTA;
            end
            ST_WAIT_DELTA: begin
                if (bus.delta_valid)
                    w_next = ST_UPDATE;
            end
            ST_UPDATE: w_next = w_exit ? ST_DONE : ST_LOAD;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pix_cnt  <= '0;
            r_sum_dr   <= '0;
            r_sum_dc   <= '0;
            r_delta_dr <= '0;
            r_delta_dc <= '0;
            r_iter     <= '0;
        end else begin
            if (w_clr) begin
                r_pix_cnt  <= '0;
                r_sum_dr   <= '0;
                r_sum_dc   <= '0;
                r_delta_dr <= '0;
                r_delta_dc <= '0;
                r_iter     <= '0;
            end
            if (w_accept)
                r_pix_cnt <= r_pix_cnt + 1'b1;
            if ((r_state == ST_WAIT_DELTA) && bus.delta_valid) begin
                r_delta_dr <= bus.delta_dr;
                r_delta_dc <= bus.delta_dc;
            end
            // Sums only move here, so they are stable through LOAD and READ.
            if (r_state == ST_UPDATE) begin
                r_sum_dr <= SUMD_INT'(sat_add(c_sat_w'(r_sum_dr), c_sat_w'(r_delta_dr),
                                              c_sat_w'(MAX_DISP)));
                r_sum_dc <= SUMD_INT'(sat_add(c_sat_w'(r_sum_dc), c_sat_w'(r_delta_dc),
                                              c_sat_w'(MAX_DISP)));
                r_iter   <= r_iter + 4'd1;
            end
        end
    end

    lk_win_watchdog #(
        .WIN_CYCLES (WIN_CYCLES)
    ) u_watchdog (
        .clk           (clk),
        .rst           (rst),
        .i_active      (r_state == ST_READ),
        .i_window_done (bus.fifo_window_done),
        .i_clr         (w_clr),
        .o_timeout     (w_timeout),
        .o_win_err     (win_err)
    );

    assign bus.fifo_clr       = w_clr;
    assign bus.fifo_w_en      = w_w_en;
    assign bus.fifo_load_addr = w_load;
    assign bus.fifo_r_en      = w_r_en;
    assign bus.sum_dr         = r_sum_dr;
    assign bus.sum_dc         = r_sum_dc;
    assign iter_count         = r_iter;
    assign busy               = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign done               = (r_state == ST_DONE);
endmodule
`default_nettype wire

// File: tb/tb_lk_window_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_lk_window_sequencer
// Brief   : Directed self-checking bench for lk_window_sequencer.
// Revision: 1.0  initial release
// ============================================================================
module tb_lk_window_sequencer;
    localparam int c_npix = 33 * 33;

    logic       clk = 1'b0;
    logic       rst, start, pix_valid;
    logic [3:0] iter_count;
    logic       busy, done, win_err;
    int         n_pass = 0;
    int         n_total = 0;

    lk_window_sequencer_if #(.SUMD_INT(6)) bus ();

    always #5 clk = ~clk;

    lk_window_sequencer #(
        .SUMD_INT(6), .ROWS(33), .COLS(33), .MAX_ITER(5), .MAX_DISP(12), .WIN_CYCLES(49)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pix_valid  (pix_valid),
        .bus        (bus.master),
        .iter_count (iter_count),
        .busy       (busy),
        .done       (done),
        .win_err    (win_err)
    );

    // ---------------- stimulus helpers (no checking inside) ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0; pix_valid = 1'b0;
        bus.fifo_full = 1'b0; bus.fifo_window_done = 1'b0;
        bus.delta_valid = 1'b0; bus.delta_dr = '0; bus.delta_dc = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Leaves the bench on the negedge of the first FILL cycle.
    task automatic do_start(output logic clr_seen);
        start = 1'b1;
        #1 clr_seen = bus.fifo_clr;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Leaves the bench on the negedge of the LOAD cycle.
    task automatic do_fill(input bit gaps, output int wen_cnt, output int wen_bad);
        logic exp_wen;
        wen_cnt = 0;
        wen_bad = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            pix_valid     = gaps ? ((cyc % 7) != 3) : 1'b1;
            bus.fifo_full = gaps ? ((cyc % 11) == 5) : 1'b0;
            bus.delta_valid = gaps;
            bus.delta_dr  = 6'sd5;
            bus.delta_dc  = -6'sd5;
            exp_wen = pix_valid & ~bus.fifo_full;
            #1;
            if (bus.fifo_w_en !== exp_wen) wen_bad++;
            if (bus.fifo_w_en === 1'b1) wen_cnt++;
            if (wen_cnt == c_npix) break;
            @(negedge clk);
        end
        @(negedge clk);
        pix_valid = 1'b0; bus.fifo_full = 1'b0; bus.delta_valid = 1'b0;
    endtask

    // Entered on the LOAD negedge; leaves on the first WAIT_DELTA negedge.
    task automatic do_window(input int done_after, output int ren_cnt, output bit load_ok);
        load_ok = (bus.fifo_load_addr === 1'b1) && (bus.fifo_r_en === 1'b0);
        ren_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.fifo_r_en !== 1'b1) break;
            ren_cnt++;
            bus.fifo_window_done = (ren_cnt == done_after);
        end
        bus.fifo_window_done = 1'b0;
    endtask

    // Entered in WAIT_DELTA; leaves on the negedge after UPDATE.
    task automatic do_delta(input int dr, input int dc);
        bus.delta_valid = 1'b1;
        bus.delta_dr = 6'(dr);
        bus.delta_dc = 6'(dc);
        @(negedge clk);
        bus.delta_valid = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0; pix_valid = 1'b0;
        bus.fifo_full = 1'b0; bus.fifo_window_done = 1'b0;
        bus.delta_valid = 1'b0; bus.delta_dr = '0; bus.delta_dc = '0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({bus.fifo_clr, bus.fifo_w_en, bus.fifo_load_addr, bus.fifo_r_en} !== 4'b0)
            $display("FAIL reset_strobes: got %b expected 0000",
                     {bus.fifo_clr, bus.fifo_w_en, bus.fifo_load_addr, bus.fifo_r_en});
        else n_pass++;
        n_total++;
        if ({bus.sum_dr, bus.sum_dc, iter_count} !== 16'h0)
            $display("FAIL reset_sums_iter: got %h expected 0", {bus.sum_dr, bus.sum_dc, iter_count});
        else n_pass++;
        n_total++;
        if ({busy, done, win_err} !== 3'b000)
            $display("FAIL reset_status: got %b expected 000", {busy, done, win_err});
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_fill();
        logic clr; int wc, wb;
        do_reset();
        do_start(clr);
        n_total++;
        if (clr !== 1'b1) $display("FAIL fill_clr: got %b expected 1", clr); else n_pass++;
        n_total++;
        if (busy !== 1'b1) $display("FAIL fill_busy: got %b expected 1", busy); else n_pass++;
        do_fill(1'b1, wc, wb);
        n_total++;
        if (wc !== c_npix) $display("FAIL fill_wen_count: got %0d expected %0d", wc, c_npix);
        else n_pass++;
        n_total++;
        if (wb !== 0) $display("FAIL fill_wen_gating: got %0d bad cycles expected 0", wb);
        else n_pass++;
        n_total++;
        if (bus.fifo_load_addr !== 1'b1 || bus.fifo_r_en !== 1'b0)
            $display("FAIL fill_load: got load=%b ren=%b expected load=1 ren=0",
                     bus.fifo_load_addr, bus.fifo_r_en);
        else n_pass++;
        n_total++;
        if (bus.sum_dr !== 6'sd0 || bus.sum_dc !== 6'sd0)
            $display("FAIL fill_delta_ignored: got %0d/%0d expected 0/0", bus.sum_dr, bus.sum_dc);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (bus.fifo_load_addr !== 1'b0 || bus.fifo_r_en !== 1'b1)
            $display("FAIL fill_read_start: got load=%b ren=%b expected load=0 ren=1",
                     bus.fifo_load_addr, bus.fifo_r_en);
        else n_pass++;
    endtask

    task automatic test_iteration();
        logic clr; int wc, wb, rc; bit lok;
        int exp_dr[5] = '{2, 4, 6, 8, 10};
        int exp_dc[5] = '{-3, -6, -9, -12, -12};
        do_reset();
        do_start(clr);
        do_fill(1'b0, wc, wb);
        for (int i = 0; i < 5; i++) begin
            do_window(49, rc, lok);
            n_total++;
            if (!lok || rc != 49)
                $display("FAIL iter_window%0d: got load_ok=%0d ren=%0d expected 1/49", i, lok, rc);
            else n_pass++;
            do_delta(2, -3);
            n_total++;
            if (bus.sum_dr != exp_dr[i] || bus.sum_dc != exp_dc[i] || iter_count != 4'(i + 1))
                $display("FAIL iter_sum%0d: got %0d/%0d it=%0d expected %0d/%0d it=%0d", i,
                         bus.sum_dr, bus.sum_dc, iter_count, exp_dr[i], exp_dc[i], i + 1);
            else n_pass++;
        end
        n_total++;
        if (done !== 1'b1 || busy !== 1'b0)
            $display("FAIL iter_done: got done=%b busy=%b expected 1/0", done, busy);
        else n_pass++;
        repeat (3) @(negedge clk);
        n_total++;
        if (bus.sum_dr != 10 || bus.sum_dc != -12 || iter_count != 4'd5)
            $display("FAIL iter_hold: got %0d/%0d it=%0d expected 10/-12 it=5",
                     bus.sum_dr, bus.sum_dc, iter_count);
        else n_pass++;
    endtask

    task automatic test_clamp();
        logic clr; int wc, wb, rc; bit lok;
        int d_dr[5]   = '{7, 7, 7, 31, -31};
        int d_dc[5]   = '{-7, -7, -7, -32, 31};
        int exp_dr[5] = '{7, 12, 12, 12, -12};
        int exp_dc[5] = '{-7, -12, -12, -12, 12};
        do_reset();
        do_start(clr);
        do_fill(1'b0, wc, wb);
        for (int i = 0; i < 5; i++) begin
            do_window(49, rc, lok);
            do_delta(d_dr[i], d_dc[i]);
            n_total++;
            if (bus.sum_dr != exp_dr[i] || bus.sum_dc != exp_dc[i])
                $display("FAIL clamp_sum%0d: got %0d/%0d expected %0d/%0d", i,
                         bus.sum_dr, bus.sum_dc, exp_dr[i], exp_dc[i]);
            else n_pass++;
        end
        n_total++;
        if (done !== 1'b1) $display("FAIL clamp_done: got %b expected 1", done); else n_pass++;
    endtask

    task automatic test_watchdog_ignore_reset();
        logic clr; int wc, wb, rc; bit lok;
        do_reset();
        do_start(clr);
        do_fill(1'b0, wc, wb);
        do_window(0, rc, lok);
        n_total++;
        if (rc != 51) $display("FAIL wd_ren_count: got %0d expected 51", rc); else n_pass++;
        n_total++;
        if (win_err !== 1'b1 || busy !== 1'b1 || bus.fifo_r_en !== 1'b0)
            $display("FAIL wd_err: got err=%b busy=%b ren=%b expected 1/1/0",
                     win_err, busy, bus.fifo_r_en);
        else n_pass++;
        do_delta(3, -4);
        n_total++;
        if (bus.sum_dr != 3 || bus.sum_dc != -4 || iter_count != 4'd1 || bus.fifo_load_addr !== 1'b1)
            $display("FAIL wd_continue: got %0d/%0d it=%0d load=%b expected 3/-4 it=1 load=1",
                     bus.sum_dr, bus.sum_dc, iter_count, bus.fifo_load_addr);
        else n_pass++;
        @(negedge clk);
        start = 1'b1;
        #1;
        n_total++;
        if (bus.fifo_clr !== 1'b0) $display("FAIL ign_start_clr: got %b expected 0", bus.fifo_clr);
        else n_pass++;
        @(negedge clk);
        start = 1'b0;
        n_total++;
        if (bus.fifo_r_en !== 1'b1 || iter_count != 4'd1 || win_err !== 1'b1 || bus.sum_dr != 3)
            $display("FAIL ign_start_state: got ren=%b it=%0d err=%b dr=%0d expected 1/1/1/3",
                     bus.fifo_r_en, iter_count, win_err, bus.sum_dr);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++;
        if ({bus.fifo_clr, bus.fifo_w_en, bus.fifo_load_addr, bus.fifo_r_en, busy, done, win_err} !== 7'b0)
            $display("FAIL async_rst_ctrl: got %b expected 0000000",
                     {bus.fifo_clr, bus.fifo_w_en, bus.fifo_load_addr, bus.fifo_r_en, busy, done, win_err});
        else n_pass++;
        n_total++;
        if ({bus.sum_dr, bus.sum_dc, iter_count} !== 16'h0)
            $display("FAIL async_rst_data: got %h expected 0", {bus.sum_dr, bus.sum_dc, iter_count});
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_early_exit();
        logic clr; int wc, wb, rc; bit lok;
        do_reset();
        do_start(clr);
        do_fill(1'b0, wc, wb);
        do_window(49, rc, lok);
        do_delta(1, 1);
        do_window(49, rc, lok);
        do_delta(0, 0);
`ifdef LK_EARLY_EXIT_EN
        n_total++;
        if (done !== 1'b1 || iter_count != 4'd2 || bus.sum_dr != 1 || bus.sum_dc != 1)
            $display("FAIL early_exit: got done=%b it=%0d %0d/%0d expected 1 it=2 1/1",
                     done, iter_count, bus.sum_dr, bus.sum_dc);
        else n_pass++;
`else
        n_total++;
        if (done !== 1'b0 || iter_count != 4'd2 || bus.fifo_load_addr !== 1'b1)
            $display("FAIL no_early_exit: got done=%b it=%0d load=%b expected 0 it=2 load=1",
                     done, iter_count, bus.fifo_load_addr);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            do_window(49, rc, lok);
            do_delta(1, 1);
        end
        n_total++;
        if (done !== 1'b1 || iter_count != 4'd5 || bus.sum_dr != 4 || bus.sum_dc != 4)
            $display("FAIL full_iter: got done=%b it=%0d %0d/%0d expected 1 it=5 4/4",
                     done, iter_count, bus.sum_dr, bus.sum_dc);
        else n_pass++;
`endif
        do_start(clr);
        n_total++;
        if (clr !== 1'b1 || iter_count != 4'd0 || bus.sum_dr != 0 || busy !== 1'b1)
            $display("FAIL restart: got clr=%b it=%0d dr=%0d busy=%b expected 1/0/0/1",
                     clr, iter_count, bus.sum_dr, busy);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_iteration();
        test_clamp();
        test_watchdog_ignore_reset();
        test_early_exit();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/lk_window_sequencer.md
# lk_window_sequencer

Iteration controller for the pyramidal-LK interpolating window buffer. It gates pixel writes into the multi-pointer row buffer until a full patch is stored. For each LK iteration it pulses address load with the current accumulated displacement, holds the window read enable until the buffer reports window completion, then waits for the solver's displacement update. It accumulates and clamps that update and repeats until the iteration budget is spent. It sits between the pixel stream, the row buffer and the LK solver.

## Interface
- SUMD_INT, 6, width of signed displacement (matches buffer `sum_dr`/`sum_dc`)
- ROWS, 33, patch rows stored in buffer
- COLS, 33, patch columns stored in buffer
- MAX_ITER, 5, LK iterations per frame (1..15)
- MAX_DISP, 12, clamp magnitude for accumulated displacement
- WIN_CYCLES, 49, expected read-enable cycles per window (7x7)
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a frame; honoured only in IDLE or DONE
- pix_valid  in  1  incoming pixel strobe
- fifo_full  in  1  buffer full flag
- fifo_window_done  in  1  buffer window-complete flag
- fifo_clr  out  1  one-cycle buffer clear pulse (ORed into buffer reset at top level)
- fifo_w_en  out  1  buffer write enable
- fifo_load_addr  out  1  buffer pointer-load pulse
- fifo_r_en  out  1  buffer read enable
- sum_dr, sum_dc  out  SUMD_INT signed  accumulated displacement to buffer
- delta_valid  in  1  solver update strobe
- delta_dr, delta_dc  in  SUMD_INT signed  solver displacement increment
- iter_count  out  4  completed iterations this frame
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  high in DONE
- win_err  out  1  sticky: window did not complete in time

## Operation
- States: IDLE, FILL, LOAD, READ, WAIT_DELTA, UPDATE, DONE.
- IDLE/DONE + start: fifo_clr=1 for that cycle; sums, iter_count, pixel counter and win_err cleared; go to FILL.
- FILL: fifo_w_en = pix_valid & ~fifo_full. Count accepted pixels. When the count reaches ROWS*COLS, go to LOAD. The accepting cycle is the last write.
- LOAD: fifo_load_addr=1 for exactly one cycle, fifo_r_en=0; go to READ.
- READ: fifo_r_en=1. A cycle with fifo_window_done=1 is the last r_en cycle; go to WAIT_DELTA. If no fifo_window_done after WIN_CYCLES+2 r_en cycles, set win_err and go to WAIT_DELTA anyway.
- WAIT_DELTA: capture delta_dr/delta_dc on delta_valid; go to UPDATE. delta_valid in any other state is ignored.
- UPDATE: sum_x <= clamp(sum_x + delta_x, -MAX_DISP, +MAX_DISP). Compute the add at SUMD_INT+1 bits before the clamp, so it never wraps. iter_count++. If the new iter_count == MAX_ITER, go to DONE; else go to LOAD.
- DONE: sums and iter_count held until next start.
- start in busy states is ignored.
- Reset values: all outputs 0, state IDLE. Asserting rst mid-operation aborts immediately to these values.

## Timing
- start -> fifo_clr in the same cycle (Mealy); FILL from the next cycle.
- Last accepted pixel -> fifo_load_addr 1 cycle later.
- fifo_load_addr -> fifo_r_en the next cycle. r_en is held WIN_CYCLES cycles nominally and drops the cycle after window_done.
- delta_valid -> updated sums 2 cycles later (capture, UPDATE). fifo_load_addr the cycle after UPDATE.
- sums are stable throughout LOAD and READ.

## Configuration
- LK_EARLY_EXIT_EN defined: in UPDATE, if captured delta_dr==0 and delta_dc==0, go to DONE regardless of iter_count. iter_count still increments.
- LK_EARLY_EXIT_EN undefined: always exactly MAX_ITER iterations.

## Structure
- Shared package lk_pkg holds:
  - the state enum
  - SUMD_INT default
  - a saturating signed add/clamp function reused by the solver
- One sub-module, lk_win_watchdog: the READ-state r_en cycle counter and win_err generation.

## Test plan
- Fill: start, 1089 pix_valid with fifo_full=0 -> exactly 1089 fifo_w_en cycles, then fifo_load_addr one cycle later.
- Iteration: window_done after 49 r_en cycles, deltas (+2,-3) x5 -> final sum_dr=+10, sum_dc=-12, iter_count=5, done=1.
- Clamp: deltas (+7,-7) x3 -> sums +12/-12, never wrap; deltas (+31,-32) -> +12/-12.
- Watchdog: window_done held low -> r_en drops after 51 cycles, win_err=1, flow continues to WAIT_DELTA.
- Early exit (LK_EARLY_EXIT_EN): second delta (0,0) -> done after iter_count=2. Without the macro, runs 5 iterations.
- Reset/ignore: rst during READ -> all outputs 0 asynchronously. start during READ and delta_valid during FILL have no effect.
